// File: rtl/mul_pkg.sv
// Shared widths and the in-flight tag type for the multiplier arbiter.
// Tag ids are sized for up to MAX_NREQ requesters so one tag type serves every instance.
package mul_pkg;

    localparam int DEF_OP_W  = 32;
    localparam int DEF_DST_W = 2 * DEF_OP_W;
    localparam int MAX_NREQ  = 16;
    localparam int ID_W      = $clog2(MAX_NREQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Round-robin successor of id among n requesters.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int n);
        return (int'(id) == n - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, ascending with wrap.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external pipelined signed multiplier among NREQ requesters (NREQ <= MAX_NREQ).
// A tag pipe aligned to MUL_LATENCY routes each product to its owner's response register.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int MUL_LATENCY = 3,
    parameter int OP_W        = DEF_OP_W,
    parameter int DST_W       = DEF_DST_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OP_W-1:0]  req_op1,
    input  logic [NREQ*OP_W-1:0]  req_op2,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*DST_W-1:0] rsp_dst,
    output logic [OP_W-1:0]       mul_op1,
    output logic [OP_W-1:0]       mul_op2,
    input  logic [DST_W-1:0]      mul_dst
);

    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rsp_fire;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic [OP_W-1:0] op1_sel;
    logic [OP_W-1:0] op2_sel;
    tag_t            tag_pipe [MUL_LATENCY];
    tag_t            tail;

    // Pending blocks re-issue until the owner drains its response, so the multiplier never stalls.
    assign eligible  = req_valid & ~pending;
    assign req_ready = gnt;
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign tail      = tag_pipe[MUL_LATENCY-1];

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req    (eligible),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .gnt_any(gnt_any)
    );

    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op1_sel = req_op1[i*OP_W +: OP_W];
                op2_sel = req_op2[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_op1 <= '0;
            mul_op2 <= '0;
            rr_ptr  <= '0;
        end else if (gnt_any) begin
            mul_op1 <= op1_sel;
            mul_op2 <= op2_sel;
            rr_ptr  <= next_id(gnt_id, NREQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: gnt_any, id: gnt_id};
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            rsp_valid <= '0;
            rsp_dst   <= '0;
        end else begin
            pending <= (pending | gnt) & ~rsp_fire;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (tail.valid && tail.id == ID_W'(i)) begin
                    rsp_valid[i]                 <= 1'b1;
                    rsp_dst[i*DST_W +: DST_W]    <= mul_dst;
                end else if (rsp_fire[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
